// File: rtl/ram_pkg.sv
// Shared sizing constants for the MIPS data memory, so the datapath and ram agree on them.
package ram_pkg;

    localparam int RAM_WORD_WIDTH = 32;
    localparam int RAM_ENTRIES    = 100;

    // The address field can encode more words than physically exist; this bounds it.
    function automatic logic addr_valid(input logic [31:0] addr, input logic [31:0] entries);
        return addr < entries;
    endfunction

endpackage

// File: rtl/ram.sv
// Single-port word-addressed data RAM: synchronous write, combinational read, async active-low clear.
module ram
    import ram_pkg::*;
#(
    parameter int WORD_WIDTH = RAM_WORD_WIDTH,
    parameter int ENTRIES    = RAM_ENTRIES,
    localparam int AW        = $clog2(ENTRIES)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [AW-1:0]         A,
    input  logic [WORD_WIDTH-1:0] WD,
    input  logic                  WE,
    output logic [WORD_WIDTH-1:0] RD
);

    logic [WORD_WIDTH-1:0] mem [ENTRIES];
    logic                  in_range;

    assign in_range = addr_valid(32'(A), 32'(ENTRIES));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (WE && in_range) begin
            mem[A] <= WD;
        end
    end

    // Gating on Rst keeps RD at zero for the whole time reset is held, not just after the clear.
    assign RD = (Rst && in_range) ? mem[A] : '0;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed cases with literal expectations plus a randomized run against an array model.
module tb_ram;

    localparam int WW  = 32;
    localparam int N   = 100;
    localparam int AW  = 7;
    localparam int AMAX = 1 << AW;

    logic          Clk;
    logic          Rst;
    logic [AW-1:0] A;
    logic [WW-1:0] WD;
    logic          WE;
    logic [WW-1:0] RD;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    logic [WW-1:0] model [AMAX];

    ram dut (
        .Clk (Clk),
        .Rst (Rst),
        .A   (A),
        .WD  (WD),
        .WE  (WE),
        .RD  (RD)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [WW-1:0] model_rd(input logic [AW-1:0] a);
        if (Rst !== 1'b1) return '0;
        if (int'(a) >= N) return '0;
        return model[a];
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: A=%0d got %h expected %h at %0t", name, A, act, exp, $time);
        end
    endtask

    // Reference model: the memory as a plain array, cleared whenever reset falls.
    always @(negedge Rst) begin
        for (int i = 0; i < AMAX; i++) model[i] = '0;
    end

    always @(posedge Clk) begin
        if (Rst === 1'b1 && WE === 1'b1 && int'(A) < N) model[A] = WD;
    end

    // Every cycle, shortly after the edge, RD must match the model for the current address.
    always @(posedge Clk) begin
        #1;
        if (cmp_en) check("model", RD, model_rd(A));
    end

    task automatic wr(input int a, input logic [WW-1:0] d);
        @(negedge Clk);
        A = AW'(a); WD = d; WE = 1'b1;
        @(negedge Clk);
        WE = 1'b0;
    endtask

    task automatic rd_check(input string name, input int a, input logic [WW-1:0] exp);
        A = AW'(a);
        #1;
        check(name, RD, exp);
    endtask

    initial begin
        for (int i = 0; i < AMAX; i++) model[i] = '0;
        Rst = 1'b0; A = '0; WD = '0; WE = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        rd_check("reset_a0", 0, 32'h0);
        rd_check("reset_a99", 99, 32'h0);
        #1 Rst = 1'b1;
        cmp_en = 1'b1;

        // Reset clears immediately without a clock edge
        wr(5, 32'hDEAD);
        rd_check("pre_reset_a5", 5, 32'hDEAD);
        #1 Rst = 1'b0;
        #1 check("async_clear_a5", RD, 32'h0);
        @(posedge Clk); #1;
        check("held_reset_a5", RD, 32'h0);
        @(negedge Clk); #1 Rst = 1'b1;
        rd_check("after_release_a5", 5, 32'h0);

        // Write / read-back
        wr(0, 32'h2); wr(1, 32'h4); wr(2, 32'h6);
        @(negedge Clk);
        rd_check("rb_a0", 0, 32'h2);
        rd_check("rb_a1", 1, 32'h4);
        rd_check("rb_a2", 2, 32'h6);

        // Write-enable gating
        A = 7'd1; WD = 32'hFFFF_FFFF; WE = 1'b0;
        repeat (3) @(negedge Clk);
        rd_check("we_gate_a1", 1, 32'h4);

        // Boundary addresses
        wr(99, 32'hA5A5_A5A5);
        wr(100, 32'h1234);
        wr(127, 32'h1234);
        @(negedge Clk);
        rd_check("bound_a99", 99, 32'hA5A5_A5A5);
        rd_check("oor_a100", 100, 32'h0);
        rd_check("oor_a127", 127, 32'h0);

        // Reset pulse between edges
        @(negedge Clk);
        #1 Rst = 1'b0;
        #3 Rst = 1'b1;
        rd_check("midrst_a0", 0, 32'h0);
        rd_check("midrst_a1", 1, 32'h0);
        rd_check("midrst_a2", 2, 32'h0);
        wr(0, 32'h7);
        @(negedge Clk);
        rd_check("post_rst_wr_a0", 0, 32'h7);

        // Read during write
        wr(3, 32'h11);
        @(negedge Clk);
        A = 7'd3; WD = 32'h22; WE = 1'b1;
        #1 check("rdw_before", RD, 32'h11);
        @(posedge Clk); #1;
        check("rdw_after", RD, 32'h22);
        @(negedge Clk); WE = 1'b0;

        // Last write wins on consecutive edges
        @(negedge Clk); A = 7'd4; WD = 32'hAAAA; WE = 1'b1;
        @(negedge Clk); WD = 32'hBBBB;
        @(negedge Clk); WE = 1'b0;
        rd_check("last_wins_a4", 4, 32'hBBBB);

        // Randomized traffic, biased toward low addresses so reads hit written data
        for (int c = 0; c < 600; c++) begin
            @(negedge Clk);
            A  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(90, AMAX - 1))
                                             : AW'($urandom_range(0, 15));
            WD = $urandom;
            WE = ($urandom_range(0, 1) == 1);
            #1 check("rand_comb", RD, model_rd(A));
            if ($urandom_range(0, 99) == 0) begin
                #1 Rst = 1'b0;
                #1 check("rand_rst_low", RD, 32'h0);
                #1 Rst = 1'b1;
            end
        end

        @(negedge Clk);
        WE = 1'b0;
        cmp_en = 1'b0;
        for (int i = 0; i < AMAX; i++) begin
            A = AW'(i);
            #1 check("final_sweep", RD, model_rd(A));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, got running expected finished");
        $fatal(1);
    end

endmodule
